// File: rtl/cnt_seq_monitor_pkg.sv
// Shared encodings for the up/down counter family: direction states and step classes.
// Direction codes match the counter blocks so dir can be compared directly.
package cnt_seq_monitor_pkg;

    localparam int unsigned RunW = 4;

    typedef enum logic [1:0] {
        DirInit = 2'b00,
        DirUp   = 2'b01,
        DirDown = 2'b10,
        DirHold = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        StepHold = 2'b00,
        StepUp   = 2'b01,
        StepDown = 2'b10,
        StepErr  = 2'b11
    } step_e;

    // DirInit doubles as "no direction yet" for last-direction tracking.
    function automatic dir_e step_to_dir(step_e s);
        case (s)
            StepUp:   return DirUp;
            StepDown: return DirDown;
            StepHold: return DirHold;
            default:  return DirInit;
        endcase
    endfunction

endpackage

// File: rtl/cnt_seq_monitor_if.sv
// Sample input and status bundle between an up/down counter and its sequence monitor.
interface cnt_seq_monitor_if
    import cnt_seq_monitor_pkg::*;
#(
    parameter int unsigned W     = 3,
    parameter int unsigned ERR_W = 8
);
    logic             en;
    logic [W-1:0]     cnt_in;
    logic [1:0]       dir;
    logic             turn;
    logic [W-1:0]     peak;
    logic [W-1:0]     trough;
    logic [RunW-1:0]  run_len;
    logic             step_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, cnt_in,
        input  dir, turn, peak, trough, run_len, step_err, err_cnt
    );

    modport slave (
        input  en, cnt_in,
        output dir, turn, peak, trough, run_len, step_err, err_cnt
    );

endinterface

// File: rtl/step_classify.sv
// Combinational classification of one count step (prev -> cnt_in) as up, down, hold or error.
module step_classify
    import cnt_seq_monitor_pkg::*;
#(
    parameter int unsigned W          = 3,
    parameter bit          ALLOW_WRAP = 1'b1
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] cnt_in,
    output step_e        step
);

    localparam logic [W-1:0] One     = W'(1);
    localparam logic [W-1:0] AllOnes = '1;

    logic [W-1:0] delta;
    logic         wrap;

    always_comb begin
        delta = cnt_in - prev;
        wrap  = ((prev == AllOnes) && (cnt_in == '0)) || ((prev == '0) && (cnt_in == AllOnes));
        step  = StepErr;
        if (delta == '0) begin
            step = StepHold;
        end else if (delta == One) begin
            step = StepUp;
        end else if (delta == AllOnes) begin
            step = StepDown;
        end
        // Without wrap support the modular +/-1 across the boundary is a jump.
        if (!ALLOW_WRAP && wrap) begin
            step = StepErr;
        end
    end

endmodule

// File: rtl/cnt_seq_monitor.sv
// Watches an up/down counter's output: tracks direction, reversals, peak/trough,
// run length and illegal steps. All outputs are registered.
module cnt_seq_monitor
    import cnt_seq_monitor_pkg::*;
#(
    parameter int unsigned W          = 3,
    parameter bit          ALLOW_WRAP = 1'b1,
    parameter int unsigned ERR_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    cnt_seq_monitor_if.slave   bus
);

    dir_e             state_q, state_d;
    dir_e             last_dir_q, last_dir_d;
    logic             primed_q, primed_d;
    logic [W-1:0]     prev_q, prev_d;
    logic             turn_q, turn_d;
    logic             step_err_q, step_err_d;
    logic [W-1:0]     peak_q, peak_d;
    logic [W-1:0]     trough_q, trough_d;
    logic [RunW-1:0]  run_len_q, run_len_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    step_e step;
    dir_e  step_dir;

    step_classify #(
        .W          (W),
        .ALLOW_WRAP (ALLOW_WRAP)
    ) u_step_classify (
        .prev   (prev_q),
        .cnt_in (bus.cnt_in),
        .step   (step)
    );

    assign step_dir = step_to_dir(step);

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        primed_d   = primed_q;
        prev_d     = prev_q;
        turn_d     = 1'b0;
        step_err_d = 1'b0;
        peak_d     = peak_q;
        trough_d   = trough_q;
        run_len_d  = run_len_q;
        err_cnt_d  = err_cnt_q;

        if (bus.en) begin
            prev_d   = bus.cnt_in;
            primed_d = 1'b1;
            // The first sample after reset only seeds prev.
            if (primed_q) begin
                unique case (step)
                    StepErr: begin
                        step_err_d = 1'b1;
                        run_len_d  = '0;
                        if (!(&err_cnt_q)) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    StepHold: begin
                        state_d = DirHold;
                    end
                    StepUp, StepDown: begin
                        state_d    = step_dir;
                        last_dir_d = step_dir;
                        if (last_dir_q == step_dir) begin
                            if (!(&run_len_q)) begin
                                run_len_d = run_len_q + 1'b1;
                            end
                        end else begin
                            run_len_d = RunW'(1);
                            // A reversal is measured against the last real move, so holds in
                            // between do not hide it.
                            if (last_dir_q != DirInit) begin
                                turn_d = 1'b1;
                                if (step_dir == DirDown) begin
                                    peak_d = prev_q;
                                end else begin
                                    trough_d = prev_q;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DirInit;
            last_dir_q <= DirInit;
            primed_q   <= 1'b0;
            prev_q     <= '0;
            turn_q     <= 1'b0;
            step_err_q <= 1'b0;
            peak_q     <= '0;
            trough_q   <= '0;
            run_len_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            primed_q   <= primed_d;
            prev_q     <= prev_d;
            turn_q     <= turn_d;
            step_err_q <= step_err_d;
            peak_q     <= peak_d;
            trough_q   <= trough_d;
            run_len_q  <= run_len_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.dir      = state_q;
    assign bus.turn     = turn_q;
    assign bus.step_err = step_err_q;
    assign bus.peak     = peak_q;
    assign bus.trough   = trough_q;
    assign bus.run_len  = run_len_q;
    assign bus.err_cnt  = err_cnt_q;

    pulse_excl_a: assert property (@(posedge clk) disable iff (rst) !(turn_q && step_err_q));

endmodule
